// File: rtl/seven_segment_scan_reader.sv
// Reads a scanned 7-segment display bus back into a DIGITS-nibble word offered on valid/ready.
// Build option: define SEG_ACTIVE_LOW_EN for active-low segment lines (blank = 7'b1111111).
module seven_segment_scan_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    input  logic                  frame_ready,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_ok,
    output logic                  frame_valid,
    output logic                  err_pulse,
    output logic                  o_dbg_state
);
    // Handshake: a frame transfers on every rising edge where frame_valid && frame_ready;
    // frame_valid never drops without that transfer, and value is stable while it is high.
    localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t                r_state, w_state_nxt;
    logic [6:0]            r_seg_s1, r_seg_s2, r_seg_prev;
    logic [DIGITS-1:0]     r_dig_s1, r_dig_s2, r_dig_prev;
    logic [CNT_W-1:0]      r_cnt;
    logic [4*DIGITS-1:0]   r_value, w_value_nxt;
    logic [DIGITS-1:0]     r_ok, w_ok_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  r_err, w_err_nxt;
    logic [6:0]            w_seg;
    logic                  w_same, w_commit, w_qual, w_match;
    logic [3:0]            w_nib;
    logic [SLOT_W-1:0]     w_slot;

`ifdef SEG_ACTIVE_LOW_EN
    assign w_seg = ~r_seg_s2;
`else
    assign w_seg = r_seg_s2;
`endif

    assign w_same   = (r_seg_s2 == r_seg_prev) && (r_dig_s2 == r_dig_prev);
    // Counter saturates past CNT_LAST, so a long stable window yields exactly one commit.
    assign w_commit = w_same && (r_cnt == CNT_LAST);
    assign w_qual   = w_commit && $onehot(r_dig_s2) && (w_seg != 7'b0000000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_s1   <= '0;
            r_seg_s2   <= '0;
            r_seg_prev <= '0;
            r_dig_s1   <= '0;
            r_dig_s2   <= '0;
            r_dig_prev <= '0;
            r_cnt      <= '0;
        end else begin
            r_seg_s1   <= seg_in;
            r_seg_s2   <= r_seg_s1;
            r_seg_prev <= r_seg_s2;
            r_dig_s1   <= dig_sel;
            r_dig_s2   <= r_dig_s1;
            r_dig_prev <= r_dig_s2;
            if (!w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_match = 1'b1;
        w_nib   = 4'h0;
        case (w_seg)
            7'b0111111: w_nib = 4'h0;
            7'b0000110: w_nib = 4'h1;
            7'b1011011: w_nib = 4'h2;
            7'b1001111: w_nib = 4'h3;
            7'b1100110: w_nib = 4'h4;
            7'b1101101: w_nib = 4'h5;
            7'b1111101: w_nib = 4'h6;
            7'b0000111: w_nib = 4'h7;
            7'b1111111: w_nib = 4'h8;
            7'b1100111: w_nib = 4'h9;
            7'b1110111: w_nib = 4'hA;
            7'b1111100: w_nib = 4'hB;
            7'b0111001: w_nib = 4'hC;
            7'b1011110: w_nib = 4'hD;
            7'b1111001: w_nib = 4'hE;
            7'b1110001: w_nib = 4'hF;
            default:    w_match = 1'b0;
        endcase
    end

    always_comb begin
        w_slot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_dig_s2[i]) w_slot = SLOT_W'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_value_nxt = r_value;
        w_ok_nxt    = r_ok;
        w_valid_nxt = r_valid;
        w_err_nxt   = w_qual && !w_match;
        case (r_state)
            COLLECT: begin
                if (w_qual) begin
                    if (w_match) w_value_nxt[{w_slot, 2'b00} +: 4] = w_nib;
                    w_ok_nxt[w_slot] = w_match;
                end
                if (&w_ok_nxt) begin
                    w_valid_nxt = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (frame_ready) begin
                    w_valid_nxt = 1'b0;
                    w_ok_nxt    = '0;
                    w_state_nxt = COLLECT;
                end
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
            r_value <= '0;
            r_ok    <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_value <= w_value_nxt;
            r_ok    <= w_ok_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign value       = r_value;
    assign digit_ok    = r_ok;
    assign frame_valid = r_valid;
    assign err_pulse   = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seven_segment_scan_reader.sv
// Bench for seven_segment_scan_reader: directed vector table plus randomized traffic
// checked every cycle against a run-length based reference model.
module tb_seven_segment_scan_reader;
    localparam int S = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = '0;
    logic [3:0]  dig_sel = '0;
    logic        frame_ready = 1'b0;
    logic [15:0] value;
    logic [3:0]  digit_ok;
    logic        frame_valid;
    logic        err_pulse;
    logic        o_dbg_state;

    int errors = 0;
    int checks = 0;
    int err_seen = 0;

    seven_segment_scan_reader #(.DIGITS(4), .STABLE_CYCLES(S), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel),
        .frame_ready(frame_ready), .value(value), .digit_ok(digit_ok),
        .frame_valid(frame_valid), .err_pulse(err_pulse), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [6:0] pat_tab [0:15] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                   7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                   7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
                                   7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    function automatic logic [6:0] enc(input logic [6:0] p);
`ifdef SEG_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    // Reference model: a digit commits when the sampled bus (two cycles late) has been
    // identical for exactly S+1 consecutive samples.
    logic [10:0] d1, d2, last_seen;
    int          run;
    logic        m_hold, m_valid, m_err;
    logic [15:0] m_val;
    logic [3:0]  m_ok;

    task automatic model_reset();
        d1 = '0; d2 = '0; last_seen = '0; run = 1;
        m_hold = 0; m_valid = 0; m_err = 0; m_val = '0; m_ok = '0;
    endtask

    task automatic model_edge();
        logic [10:0] seen;
        logic [6:0]  pat;
        logic [3:0]  dsel;
        logic        qual, found;
        int          nib, slot;
        seen = d2;
        if (seen == last_seen) run = (run < 1000) ? run + 1 : run;
        else run = 1;
        last_seen = seen;
        d2 = d1;
        d1 = {dig_sel, seg_in};
        dsel = seen[10:7];
        pat  = enc(seen[6:0]);
        qual = (run == S + 1) && ($countones(dsel) == 1) && (pat != 7'b0);
        found = 0; nib = 0; slot = 0;
        for (int i = 0; i < 16; i++) if (pat_tab[i] == pat) begin found = 1; nib = i; end
        for (int i = 0; i < 4; i++) if (dsel[i]) slot = i;
        m_err = qual && !found;
        if (!m_hold) begin
            if (qual) begin
                if (found) m_val[slot*4 +: 4] = nib[3:0];
                m_ok[slot] = found;
            end
            if (m_ok == 4'hF) begin m_valid = 1; m_hold = 1; end
        end else if (frame_ready) begin
            m_valid = 0; m_ok = '0; m_hold = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("value", 32'(value), 32'(m_val));
        chk("digit_ok", 32'(digit_ok), 32'(m_ok));
        chk("frame_valid", 32'(frame_valid), 32'(m_valid));
        chk("err_pulse", 32'(err_pulse), 32'(m_err));
        chk("state", 32'(o_dbg_state), 32'(m_hold));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        if (err_pulse === 1'b1) err_seen++;
        compare_model();
    endtask

    typedef struct {
        logic [6:0]  seg;
        logic [3:0]  dig;
        logic        rdy;
        int          n;
        logic [15:0] ev;
        logic [3:0]  eok;
        logic        evalid;
        int          eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [6:0] seg, input logic [3:0] dig, input logic rdy,
                                input int n, input logic [15:0] ev, input logic [3:0] eok,
                                input logic evalid, input int eerr);
        vec_t v;
        v.seg = seg; v.dig = dig; v.rdy = rdy; v.n = n;
        v.ev = ev; v.eok = eok; v.evalid = evalid; v.eerr = eerr;
        return v;
    endfunction

    task automatic random_traffic(input int segs);
        int kind, n;
        for (int s = 0; s < segs; s++) begin
            kind = $urandom_range(0, 9);
            n = $urandom_range(1, 14);
            frame_ready = ($urandom_range(0, 3) == 0);
            if (kind <= 5) begin
                seg_in = enc(pat_tab[$urandom_range(0, 15)]);
                dig_sel = 4'b0001 << $urandom_range(0, 3);
                n = $urandom_range(8, 14);
            end else if (kind == 6) begin
                seg_in = 7'($urandom);
                dig_sel = 4'b0001 << $urandom_range(0, 3);
            end else if (kind == 7) begin
                seg_in = enc(7'b0);
                dig_sel = 4'b0001 << $urandom_range(0, 3);
            end else begin
                seg_in = enc(pat_tab[$urandom_range(0, 15)]);
                dig_sel = 4'($urandom);
            end
            repeat (n) cycle();
        end
    endtask

    initial begin
        vecs.push_back(mk(7'b0111111, 4'b0001, 0, 12, 16'h0000, 4'h1, 0, 0));
        vecs.push_back(mk(7'b1001111, 4'b0010, 0, 12, 16'h0030, 4'h3, 0, 0));
        vecs.push_back(mk(7'b1111001, 4'b0100, 0, 12, 16'h0E30, 4'h7, 0, 0));
        vecs.push_back(mk(7'b0000110, 4'b1000, 0, 12, 16'h1E30, 4'hF, 1, 0));
        vecs.push_back(mk(7'b0000000, 4'b0000, 1,  1, 16'h1E30, 4'h0, 0, 0));
        vecs.push_back(mk(7'b1011011, 4'b0010, 0,  5, 16'h1E30, 4'h0, 0, 0));
        vecs.push_back(mk(7'b0000000, 4'b0000, 0,  3, 16'h1E30, 4'h0, 0, 0));
        vecs.push_back(mk(7'b1011011, 4'b0100, 0, 12, 16'h1230, 4'h4, 0, 0));
        vecs.push_back(mk(7'b0000001, 4'b0100, 0, 20, 16'h1230, 4'h0, 0, 1));
        vecs.push_back(mk(7'b0111111, 4'b0011, 0, 20, 16'h1230, 4'h0, 0, 0));
        vecs.push_back(mk(7'b0111111, 4'b0000, 0, 20, 16'h1230, 4'h0, 0, 0));
        vecs.push_back(mk(7'b0000000, 4'b0001, 0, 20, 16'h1230, 4'h0, 0, 0));
        vecs.push_back(mk(7'b0000111, 4'b0001, 0, 12, 16'h1237, 4'h1, 0, 0));
        vecs.push_back(mk(7'b1111111, 4'b0010, 0, 12, 16'h1287, 4'h3, 0, 0));
        vecs.push_back(mk(7'b1100111, 4'b0100, 0, 12, 16'h1987, 4'h7, 0, 0));
        vecs.push_back(mk(7'b1110111, 4'b1000, 0, 12, 16'hA987, 4'hF, 1, 0));
        vecs.push_back(mk(7'b1110111, 4'b0001, 0, 12, 16'hA987, 4'hF, 1, 0));
        vecs.push_back(mk(7'b0000001, 4'b0001, 0, 20, 16'hA987, 4'hF, 1, 1));
        // Ready arrives on the very edge slot 0 commits 'F': that commit is dropped.
        vecs.push_back(mk(7'b1110001, 4'b0001, 0, 10, 16'hA987, 4'hF, 1, 0));
        vecs.push_back(mk(7'b1110001, 4'b0001, 1,  1, 16'hA987, 4'h0, 0, 0));
        vecs.push_back(mk(7'b1110001, 4'b0001, 0, 10, 16'hA987, 4'h0, 0, 0));
        vecs.push_back(mk(7'b0000000, 4'b0000, 1,  3, 16'hA987, 4'h0, 0, 0));

        model_reset();
        seg_in = enc(7'b0);
        repeat (2) @(posedge clk);
        #1;
        compare_model();
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            seg_in = enc(vecs[i].seg);
            dig_sel = vecs[i].dig;
            frame_ready = vecs[i].rdy;
            err_seen = 0;
            repeat (vecs[i].n) cycle();
            chk($sformatf("vec%0d_value", i), 32'(value), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_ok", i), 32'(digit_ok), 32'(vecs[i].eok));
            chk($sformatf("vec%0d_valid", i), 32'(frame_valid), 32'(vecs[i].evalid));
            chk($sformatf("vec%0d_errs", i), 32'(err_seen), 32'(vecs[i].eerr));
        end

        random_traffic(200);

        // Asynchronous reset in the middle of a digit window.
        frame_ready = 1'b0;
        seg_in = enc(pat_tab[5]);
        dig_sel = 4'b0100;
        repeat (5) cycle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async_value", 32'(value), 32'h0);
        chk("rst_async_ok", 32'(digit_ok), 32'h0);
        chk("rst_async_valid", 32'(frame_valid), 32'h0);
        chk("rst_async_err", 32'(err_pulse), 32'h0);
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (4) cycle();
        chk("post_rst_ok", 32'(digit_ok), 32'h0);
        repeat (12) cycle();
        chk("post_rst_value", 32'(value), 32'h0500);
        chk("post_rst_ok2", 32'(digit_ok), 32'h4);

        random_traffic(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
